// File: rtl/text_vram.sv
// Text-mode video RAM: 30x100 character grid with a terminal-style writer and a scrolling top row.
// Optional TEXT_VRAM_TAB_EN macro enables horizontal tab handling (0x09).
module text_vram (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    input  logic       vram_valid,
    input  logic [4:0] vram_row,
    input  logic [6:0] vram_col,
    output logic [7:0] vram_char,
    output logic [4:0] top_row,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col
);

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t     state_q;
    logic [4:0] top_row_q, cursor_row_q, sweep_row_q;
    logic [6:0] cursor_col_q, sweep_col_q;
    logic [6:0] cursor_col_d;
    logic       newline_d;
    logic       accept, is_print;
    logic [5:0] phys_sum;
    logic [4:0] phys_row;
`ifdef TEXT_VRAM_TAB_EN
    logic [6:0] tab_col;
`endif

    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem [0:3839];
    logic [7:0]  vram_char_q;

    always_comb begin
        accept   = in_valid && (state_q == IDLE);
        is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);
        phys_sum = {1'b0, top_row_q} + {1'b0, cursor_row_q};
        // Sums 30..58 wrap to 0..28; in 5 bits, subtracting 30 equals adding 2.
        phys_row = (phys_sum >= 6'd30) ? phys_sum[4:0] + 5'd2 : phys_sum[4:0];

        cursor_col_d = cursor_col_q;
        newline_d    = 1'b0;
`ifdef TEXT_VRAM_TAB_EN
        tab_col      = {cursor_col_q[6:3], 3'b000} + 7'd8;
`endif
        if (accept) begin
            if (is_print) begin
                if (cursor_col_q == 7'd99) begin
                    cursor_col_d = 7'd0;
                    newline_d    = 1'b1;
                end else begin
                    cursor_col_d = cursor_col_q + 7'd1;
                end
            end else begin
                case (in_char)
                    8'h0D: cursor_col_d = 7'd0;
                    8'h0A: newline_d = 1'b1;
                    8'h08: if (cursor_col_q != 7'd0) cursor_col_d = cursor_col_q - 7'd1;
`ifdef TEXT_VRAM_TAB_EN
                    8'h09: begin
                        if (tab_col >= 7'd100) begin
                            cursor_col_d = 7'd0;
                            newline_d    = 1'b1;
                        end else begin
                            cursor_col_d = tab_col;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        // INIT and CLEAR share the sweep counters; IDLE writes only printable bytes.
        mem_we    = 1'b0;
        mem_waddr = {sweep_row_q, sweep_col_q};
        mem_wdata = 8'h20;
        case (state_q)
            INIT, CLEAR: mem_we = 1'b1;
            IDLE: begin
                if (accept && is_print) begin
                    mem_we    = 1'b1;
                    mem_waddr = {phys_row, cursor_col_q};
                    mem_wdata = in_char;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q      <= INIT;
            top_row_q    <= 5'd0;
            cursor_row_q <= 5'd0;
            cursor_col_q <= 7'd0;
            sweep_row_q  <= 5'd0;
            sweep_col_q  <= 7'd0;
        end else begin
            case (state_q)
                INIT: begin
                    if (sweep_col_q == 7'd99) begin
                        sweep_col_q <= 7'd0;
                        if (sweep_row_q == 5'd29) begin
                            sweep_row_q <= 5'd0;
                            state_q     <= IDLE;
                        end else begin
                            sweep_row_q <= sweep_row_q + 5'd1;
                        end
                    end else begin
                        sweep_col_q <= sweep_col_q + 7'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        cursor_col_q <= cursor_col_d;
                        if (newline_d) begin
                            if (cursor_row_q != 5'd29) begin
                                cursor_row_q <= cursor_row_q + 5'd1;
                            end else begin
                                // The old top row becomes the new bottom row and is blanked.
                                top_row_q   <= (top_row_q == 5'd29) ? 5'd0 : top_row_q + 5'd1;
                                sweep_row_q <= top_row_q;
                                sweep_col_q <= 7'd0;
                                state_q     <= CLEAR;
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (sweep_col_q == 7'd99) begin
                        sweep_col_q <= 7'd0;
                        state_q     <= IDLE;
                    end else begin
                        sweep_col_q <= sweep_col_q + 7'd1;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            vram_char_q <= 8'h00;
        end else if (vram_valid) begin
            vram_char_q <= (vram_row < 5'd30) ? mem[{vram_row, vram_col}] : 8'h00;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign vram_char  = vram_char_q;
    assign top_row    = top_row_q;
    assign cursor_row = cursor_row_q;
    assign cursor_col = cursor_col_q;

endmodule

// File: tb/tb_text_vram.sv
// Directed self-checking bench for text_vram: init sweep, printing, control bytes, scrolling, resets.
// Define TEXT_VRAM_TAB_EN on both bench and RTL to exercise tab handling.
module tb_text_vram;

    logic       clk = 1'b0;
    logic       reset_low;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       vram_valid;
    logic [4:0] vram_row;
    logic [6:0] vram_col;
    logic [7:0] vram_char;
    logic [4:0] top_row;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;

    int checks = 0;
    int errors = 0;
    int busy;

    text_vram dut (
        .clk        (clk),
        .reset_low  (reset_low),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .vram_valid (vram_valid),
        .vram_row   (vram_row),
        .vram_col   (vram_col),
        .vram_char  (vram_char),
        .top_row    (top_row),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_char  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic countBusy(input int budget, output int n);
        n = 0;
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic checkCell(input string tag, input logic [4:0] r, input logic [6:0] c,
                             input logic [7:0] exp);
        vram_valid = 1'b1;
        vram_row   = r;
        vram_col   = c;
        @(negedge clk);
        vram_valid = 1'b0;
        checkOutput(tag, 32'(vram_char), 32'(exp));
    endtask

    task automatic checkCursor(input string tag, input logic [4:0] expTop,
                               input logic [4:0] expRow, input logic [6:0] expCol);
        checkOutput({tag, "_top"}, 32'(top_row), 32'(expTop));
        checkOutput({tag, "_row"}, 32'(cursor_row), 32'(expRow));
        checkOutput({tag, "_col"}, 32'(cursor_col), 32'(expCol));
    endtask

    initial begin
        reset_low  = 1'b0;
        in_valid   = 1'b0;
        in_char    = 8'h00;
        vram_valid = 1'b0;
        vram_row   = 5'd0;
        vram_col   = 7'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_vram_char", 32'(vram_char), 32'd0);
        checkCursor("reset", 5'd0, 5'd0, 7'd0);

        // Abort a partial INIT, then time a full one.
        reset_low = 1'b1;
        repeat (500) @(negedge clk);
        checkOutput("mid_init_ready", 32'(in_ready), 32'd0);
        reset_low = 1'b0;
        @(negedge clk);
        reset_low = 1'b1;
        countBusy(4000, busy);
        checkOutput("init_cycles", 32'(busy), 32'd3000);
        checkCell("init_0_0", 5'd0, 7'd0, 8'h20);
        checkCell("init_29_99", 5'd29, 7'd99, 8'h20);
        checkCell("init_15_50", 5'd15, 7'd50, 8'h20);

        // Write and read the same cell in one cycle: old data returned.
        in_valid   = 1'b1;
        in_char    = 8'h41;
        vram_valid = 1'b1;
        vram_row   = 5'd0;
        vram_col   = 7'd0;
        @(negedge clk);
        in_valid   = 1'b0;
        vram_valid = 1'b0;
        checkOutput("same_cycle_read", 32'(vram_char), 32'h20);
        checkCursor("after_A", 5'd0, 5'd0, 7'd1);
        checkCell("cell_A", 5'd0, 7'd0, 8'h41);

        applyStimulus(8'h08);
        checkCursor("bs1", 5'd0, 5'd0, 7'd0);
        applyStimulus(8'h08);
        checkCursor("bs_sat", 5'd0, 5'd0, 7'd0);
        checkCell("bs_no_write", 5'd0, 7'd0, 8'h41);
        applyStimulus(8'h78);
        applyStimulus(8'h79);
        checkCursor("xy", 5'd0, 5'd0, 7'd2);
        checkCell("cell_y", 5'd0, 7'd1, 8'h79);
        applyStimulus(8'h0D);
        checkCursor("cr", 5'd0, 5'd0, 7'd0);
        applyStimulus(8'h07);
        checkCursor("bel", 5'd0, 5'd0, 7'd0);
        checkCell("cell_x", 5'd0, 7'd0, 8'h78);
        checkCell("cr_no_write", 5'd0, 7'd2, 8'h20);

        applyStimulus(8'h61);
        applyStimulus(8'h62);
        applyStimulus(8'h63);
        applyStimulus(8'h09);
`ifdef TEXT_VRAM_TAB_EN
        checkCursor("tab_3", 5'd0, 5'd0, 7'd8);
`else
        checkCursor("tab_3", 5'd0, 5'd0, 7'd3);
`endif
        checkCell("tab_no_write", 5'd0, 7'd3, 8'h20);
        applyStimulus(8'h0D);

        // A full row of 'B' wraps the cursor to the next row.
        for (int i = 0; i < 100; i++) applyStimulus(8'h42);
        checkCursor("row_full", 5'd0, 5'd1, 7'd0);
        for (int i = 0; i < 100; i++) checkCell("row0_B", 5'd0, 7'(i), 8'h42);
        checkCell("row1_blank", 5'd1, 7'd0, 8'h20);

        // Fill down to the bottom row, then scroll.
        applyStimulus(8'h43);
        for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
        checkCursor("bottom", 5'd0, 5'd29, 7'd1);
        applyStimulus(8'h0A);
        checkCursor("scroll1", 5'd1, 5'd29, 7'd1);
        countBusy(200, busy);
        checkOutput("clear_cycles", 32'(busy), 32'd100);
        for (int i = 0; i < 100; i++) checkCell("row0_cleared", 5'd0, 7'(i), 8'h20);
        checkCell("cell_C", 5'd1, 7'd0, 8'h43);

        // Bottom logical row now maps to physical row 0.
        applyStimulus(8'h5A);
        checkCell("wrapped_write", 5'd0, 7'd1, 8'h5A);
        checkCursor("after_Z", 5'd1, 5'd29, 7'd2);

        for (int i = 0; i < 97; i++) applyStimulus(8'h57);
        checkCursor("col99", 5'd1, 5'd29, 7'd99);
        applyStimulus(8'h57);
        checkCursor("col_wrap_scroll", 5'd2, 5'd29, 7'd0);
        countBusy(200, busy);
        checkOutput("clear_cycles2", 32'(busy), 32'd100);
        checkCell("last_W", 5'd0, 7'd99, 8'h57);
        checkCell("first_W", 5'd0, 7'd2, 8'h57);
        checkCell("row1_cleared", 5'd1, 7'd0, 8'h20);

        for (int i = 0; i < 27; i++) applyStimulus(8'h0A);
        checkCursor("top29", 5'd29, 5'd29, 7'd0);
        applyStimulus(8'h0A);
        checkCursor("top_wrap", 5'd0, 5'd29, 7'd0);

        // Reset in the middle of a CLEAR sweep restarts a full INIT.
        applyStimulus(8'h0A);
        repeat (10) @(negedge clk);
        reset_low = 1'b0;
        @(negedge clk);
        checkCursor("mid_clear_reset", 5'd0, 5'd0, 7'd0);
        checkOutput("mid_clear_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_clear_vram_char", 32'(vram_char), 32'd0);
        reset_low = 1'b1;
        countBusy(4000, busy);
        checkOutput("reinit_cycles", 32'(busy), 32'd3000);
        checkCell("reinit_0_50", 5'd0, 7'd50, 8'h20);
        checkCell("reinit_0_1", 5'd0, 7'd1, 8'h20);

`ifdef TEXT_VRAM_TAB_EN
        for (int i = 0; i < 96; i++) applyStimulus(8'h2E);
        checkCursor("col96", 5'd0, 5'd0, 7'd96);
        applyStimulus(8'h09);
        checkCursor("tab_wrap", 5'd0, 5'd1, 7'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
